// File: rtl/io_periph_pkg.sv
// io_periph_pkg: shared op and FSM state encodings for the I/O peripheral unit
package io_periph_pkg;
  typedef enum logic [1:0] {
    OP_LED = 2'b00,
    OP_CAP = 2'b01,
    OP_THR = 2'b10,
    OP_RSV = 2'b11
  } op_e;
  typedef enum logic [1:0] {
    IDLE = 2'b00,
    EXEC = 2'b01,
    RESP = 2'b10
  } state_e;
endpackage

// File: rtl/cap_threshold.sv
// cap_threshold: threshold register plus registered per-channel sensor-above-threshold flags
module cap_threshold #(
  parameter int NUM_CH = 9,
  parameter int SENS_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     we_i,
  input  logic [DATA_W-1:0]        wdata_i,
  input  logic [NUM_CH*SENS_W-1:0] sensor_readings_i,
  output logic [NUM_CH-1:0]        touched_o
);
  logic [DATA_W-1:0] thr_q;
  logic [NUM_CH-1:0] touched_d, touched_q;
  // compare every channel against the currently held threshold
  always_comb begin
    touched_d = '0;
    for (int i = 0; i < NUM_CH; i++) touched_d[i] = DATA_W'(sensor_readings_i[i*SENS_W +: SENS_W]) > thr_q;
  end
  // all-ones threshold out of reset so nothing reads as touched
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      thr_q     <= '1;
      touched_q <= '0;
    end else begin
      touched_q <= touched_d;
      if (we_i) thr_q <= wdata_i;
    end
  end
  assign touched_o = touched_q;
endmodule

// File: rtl/io_peripheral_unit.sv
// io_peripheral_unit: LED/cap-sensor register file with valid/ready command/response; CAP_THRESHOLD_EN adds touch detection
module io_peripheral_unit
  import io_periph_pkg::*;
#(
  parameter int NUM_CH = 9,
  parameter int LED_W  = 16,
  parameter int SENS_W = 32,
  parameter int DATA_W = 32,
  parameter int SEL_W  = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [1:0]               cmd_op_i,
  input  logic [SEL_W-1:0]         cmd_sel_i,
  input  logic [DATA_W-1:0]        cmd_data_i,
  output logic                     rsp_valid_o,
  input  logic                     rsp_ready_i,
  output logic [DATA_W-1:0]        rsp_data_o,
  output logic                     rsp_err_o,
  input  logic [NUM_CH*SENS_W-1:0] sensor_readings_i,
  output logic [NUM_CH*LED_W-1:0]  led_commands_o,
  output logic [NUM_CH-1:0]        touched_o
);
  state_e                  state_q, state_d;
  op_e                     op_q, op_d;
  logic [SEL_W-1:0]        sel_q, sel_d;
  logic [DATA_W-1:0]       data_q, data_d, rsp_data_q, rsp_data_d;
  logic [NUM_CH*LED_W-1:0] led_q, led_d;
  logic                    rsp_err_q, rsp_err_d, ch_ok, err;
  logic [SENS_W-1:0]       sens_sel;
  assign ch_ok    = 32'(sel_q) < NUM_CH;
  assign sens_sel = sensor_readings_i[32'(sel_q)*SENS_W +: SENS_W];
`ifdef CAP_THRESHOLD_EN
  assign err = (op_q == OP_RSV) || (op_q != OP_THR && !ch_ok);
`else
  assign err = (op_q == OP_RSV) || (op_q == OP_THR) || !ch_ok;
`endif
  // IDLE latches a command, EXEC acts and loads the response, RESP holds it until taken
  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    sel_d      = sel_q;
    data_d     = data_q;
    led_d      = led_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    case (state_q)
      IDLE: if (cmd_valid_i) begin
        state_d = EXEC;
        op_d    = op_e'(cmd_op_i);
        sel_d   = cmd_sel_i;
        data_d  = cmd_data_i;
      end
      EXEC: begin
        state_d    = RESP;
        rsp_err_d  = err;
        rsp_data_d = (err || op_q != OP_CAP) ? '0 : DATA_W'(sens_sel);
        if (!err && op_q == OP_LED) led_d[32'(sel_q)*LED_W +: LED_W] = data_q[LED_W-1:0];
      end
      RESP:    state_d = rsp_ready_i ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  // state and datapath registers; reset drops any in-flight command
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      op_q       <= OP_LED;
      sel_q      <= '0;
      data_q     <= '0;
      led_q      <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      sel_q      <= sel_d;
      data_q     <= data_d;
      led_q      <= led_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
    end
  end
  assign cmd_ready_o    = state_q == IDLE && !rst_i;
  assign rsp_valid_o    = state_q == RESP;
  assign rsp_data_o     = rsp_data_q;
  assign rsp_err_o      = rsp_err_q;
  assign led_commands_o = led_q;
`ifdef CAP_THRESHOLD_EN
  cap_threshold #(
    .NUM_CH(NUM_CH),
    .SENS_W(SENS_W),
    .DATA_W(DATA_W)
  ) u_cap_threshold (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .we_i             (state_q == EXEC && op_q == OP_THR),
    .wdata_i          (data_q),
    .sensor_readings_i(sensor_readings_i),
    .touched_o        (touched_o)
  );
`else
  logic unused_data;
  assign unused_data = ^data_q[DATA_W-1:LED_W];
  assign touched_o   = '0;
`endif
endmodule

// File: tb/tb_io_peripheral_unit.sv
// tb_io_peripheral_unit: directed plus randomized checks against a transaction-level model
module tb_io_peripheral_unit;
  localparam int NUM_CH = 9, LED_W = 16, SENS_W = 32, DATA_W = 32, SEL_W = 4;
  localparam int LW = NUM_CH * LED_W;
`ifdef CAP_THRESHOLD_EN
  localparam bit THR_EN = 1'b1;
`else
  localparam bit THR_EN = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid = 1'b0, cmd_ready, rsp_valid, rsp_ready = 1'b1, rsp_err;
  logic [1:0] cmd_op = '0;
  logic [SEL_W-1:0] cmd_sel = '0;
  logic [DATA_W-1:0] cmd_data = '0, rsp_data;
  logic [NUM_CH*SENS_W-1:0] sens = '0;
  logic [LW-1:0] leds, el;
  logic [NUM_CH-1:0] touched;
  always #5 clk = ~clk;
  io_peripheral_unit #(
    .NUM_CH(NUM_CH), .LED_W(LED_W), .SENS_W(SENS_W), .DATA_W(DATA_W), .SEL_W(SEL_W)
  ) dut (
    .clk_i(clk), .rst_i(rst), .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready),
    .cmd_op_i(cmd_op), .cmd_sel_i(cmd_sel), .cmd_data_i(cmd_data),
    .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
    .sensor_readings_i(sens), .led_commands_o(leds), .touched_o(touched)
  );
  int errs = 0, checks = 0, cyc = 0;
  bit chk_on = 1'b0;
  bit m_free, m_exec, m_have, m_rerr;
  logic [1:0] m_op;
  logic [SEL_W-1:0] m_sel;
  logic [DATA_W-1:0] m_dat, m_thr, m_rdata;
  logic [LED_W-1:0] m_led [NUM_CH];
  logic [NUM_CH-1:0] m_touch;
  int acc[$];
  logic [DATA_W-1:0] got[$];
  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  // transaction-level model: one command in flight, executes the edge after acceptance, held until taken
  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_free = 1; m_exec = 0; m_have = 0; m_rerr = 0; m_rdata = 0; m_thr = '1; m_touch = '0;
      foreach (m_led[i]) m_led[i] = '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) m_touch[i] = THR_EN && (sens[i*SENS_W +: SENS_W] > m_thr);
      if (m_have) begin
        if (rsp_ready) begin m_have = 0; m_free = 1; end
      end else if (m_exec) begin
        m_rerr = (m_op == 3) || (m_op == 2 && !THR_EN) || (m_op != 2 && int'(m_sel) >= NUM_CH);
        m_rdata = (!m_rerr && m_op == 1) ? sens[int'(m_sel)*SENS_W +: SENS_W] : '0;
        if (!m_rerr && m_op == 0) m_led[m_sel] = m_dat[LED_W-1:0];
        if (!m_rerr && m_op == 2) m_thr = m_dat;
        m_exec = 0; m_have = 1;
      end else if (m_free && cmd_valid) begin
        m_op = cmd_op; m_sel = cmd_sel; m_dat = cmd_data; m_exec = 1; m_free = 0;
      end
    end
  end
  // per-cycle comparison of every output against the model
  always @(negedge clk) if (chk_on) begin
    for (int i = 0; i < NUM_CH; i++) el[i*LED_W +: LED_W] = m_led[i];
    chk("cmd_ready", cmd_ready, m_free && !rst);
    chk("rsp_valid", rsp_valid, m_have);
    if (m_have) begin
      chk("rsp_data", rsp_data, m_rdata);
      chk("rsp_err", rsp_err, m_rerr);
    end
    chk("led_commands", leds, el);
    chk("touched", touched, m_touch);
  end
  always @(negedge clk) begin
    if (cmd_valid && cmd_ready && !rst) acc.push_back(cyc);
    if (rsp_valid && rsp_ready && !rst) got.push_back(rsp_data);
  end
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [1:0] op, input logic [SEL_W-1:0] sel, input logic [DATA_W-1:0] d);
    int n = 0;
    cmd_valid = 1; cmd_op = op; cmd_sel = sel; cmd_data = d;
    @(negedge clk);
    while (!cmd_ready && n < 20) begin @(negedge clk); n++; end
    if (n >= 20) begin
      errs++; checks++;
      $display("FAIL accept timeout: got no cmd_ready expected within 20 cycles");
    end
    @(posedge clk);
    #1 cmd_valid = 0;
  endtask
  initial begin
    step; step; chk_on = 1; step;
    rst = 0;
    @(negedge clk);
    chk("reset cmd_ready", cmd_ready, 1);
    chk("reset leds", leds, 0);
    chk("reset rsp_valid", rsp_valid, 0);
    chk("reset rsp_data", rsp_data, 0);
    chk("reset rsp_err", rsp_err, 0);
    chk("reset touched", touched, 0);
    step;
    send(2'b00, 4'd3, 32'h0000ABCD); step;
    chk("led slice3", leds[63:48], 16'hABCD);
    chk("led others", leds & ~({{(LW-16){1'b0}}, 16'hFFFF} << 48), 0);
    chk("led rsp_valid", rsp_valid, 1);
    chk("led rsp_err", rsp_err, 0);
    step;
    rsp_ready = 0; sens[8*SENS_W +: SENS_W] = 32'h12345678;
    send(2'b01, 4'd8, 0); step;
    sens[8*SENS_W +: SENS_W] = 0;
    repeat (5) begin
      step;
      chk("cap hold valid", rsp_valid, 1);
      chk("cap hold data", rsp_data, 32'h12345678);
    end
    rsp_ready = 1; step;
    chk("cap released", rsp_valid, 0);
    send(2'b00, 4'd9, 32'hFFFF); step;
    chk("bad ch err", rsp_err, 1);
    chk("bad ch data", rsp_data, 0);
    chk("bad ch leds", leds, {{(LW-16){1'b0}}, 16'hABCD} << 48);
    step;
    send(2'b00, 4'd0, 32'h1234);
    rst = 1; step;
    chk("rst mid leds", leds, 0);
    chk("rst mid rsp_valid", rsp_valid, 0);
    rst = 0;
    @(negedge clk);
    chk("rst mid ready", cmd_ready, 1);
    step;
    sens = '0; sens[2*SENS_W +: SENS_W] = 101; sens[5*SENS_W +: SENS_W] = 100;
    send(2'b10, 4'd0, 100); step;
    chk("thr rsp_err", rsp_err, !THR_EN);
    step;
    chk("thr touched", touched, THR_EN ? 9'b000000100 : 9'b0);
    step;
    acc.delete(); got.delete();
    sens[0 +: SENS_W] = 32'hA0; sens[SENS_W +: SENS_W] = 32'hB1; sens[4*SENS_W +: SENS_W] = 32'hC4;
    send(2'b01, 4'd0, 0); send(2'b01, 4'd1, 0); send(2'b01, 4'd4, 0);
    repeat (4) step;
    chk("b2b accepts", acc.size(), 3);
    if (acc.size() == 3) begin
      chk("b2b gap1", acc[1] - acc[0], 3);
      chk("b2b gap2", acc[2] - acc[1], 3);
    end
    chk("b2b responses", got.size(), 3);
    if (got.size() == 3) begin
      chk("b2b rsp0", got[0], 32'hA0);
      chk("b2b rsp1", got[1], 32'hB1);
      chk("b2b rsp2", got[2], 32'hC4);
    end
    repeat (800) begin
      step;
      rst = $urandom_range(0, 99) == 0;
      cmd_valid = $urandom_range(0, 1) == 1;
      cmd_op = 2'($urandom);
      cmd_sel = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(9, 15)) : 4'($urandom_range(0, 8));
      cmd_data = ($urandom_range(0, 2) == 0) ? $urandom : 32'($urandom_range(0, 255));
      rsp_ready = $urandom_range(0, 3) != 0;
      if ($urandom_range(0, 3) == 0)
        for (int i = 0; i < NUM_CH; i++) sens[i*SENS_W +: SENS_W] = ($urandom_range(0, 7) == 0) ? $urandom : 32'($urandom_range(0, 255));
    end
    rst = 0; cmd_valid = 0; rsp_ready = 1;
    step; step; step;
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/io_peripheral_unit.md
# io_peripheral_unit

- Parametrised LED/capacitive-sensor peripheral for the processor's I/O path.
- Replaces the fixed 9-channel decode with a channel-count-generic register file and a valid/ready command/response handshake.
- The execute stage issues LED writes and sensor reads as commands; responses come back with an error flag for invalid commands.
- Sensor values are snapshotted at execution time, so the returned data is stable while held.

## Interface
- NUM_CH, 9, number of LED/sensor channels (1..16)
- LED_W, 16, bits per LED command slice
- SENS_W, 32, bits per sensor reading (≤ DATA_W)
- DATA_W, 32, command/response data width
- SEL_W, 4, channel-select width (2^SEL_W ≥ NUM_CH)
- clock  in  1  single clock; all state updates on rising edge
- reset  in  1  synchronous, active-high
- cmd_valid  in  1  command offered
- cmd_ready  out  1  unit can accept a command; high only in IDLE
- cmd_op  in  2  00 LED write, 01 CAP read, 10 threshold write, 11 reserved
- cmd_sel  in  SEL_W  channel index
- cmd_data  in  DATA_W  write data; LED uses [LED_W-1:0]
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer accepts the response
- rsp_data  out  DATA_W  read data, zero-extended sensor value; 0 for writes and errors
- rsp_err  out  1  invalid channel or unsupported op
- sensor_readings  in  NUM_CH*SENS_W  channel i occupies [i*SENS_W +: SENS_W]
- led_commands  out  NUM_CH*LED_W  channel i occupies [i*LED_W +: LED_W]
- touched  out  NUM_CH  per-channel threshold hit (see Configuration)

## Operation
- FSM states:
  - IDLE: cmd_ready=1. On cmd_valid, latch op/sel/data and go to EXEC.
  - EXEC: perform the action for one cycle, load rsp_data/rsp_err, go to RESP.
  - RESP: rsp_valid=1. On rsp_ready go to IDLE, otherwise hold.
- LED write, valid channel: slice sel ← cmd_data[LED_W-1:0]. Other slices are unchanged. rsp_data=0, rsp_err=0.
- CAP read, valid channel: rsp_data ← zero-extended sensor_readings slice sampled on the EXEC edge. Later sensor changes do not alter the held response.
- Threshold write (10): see Configuration.
- Invalid channel (sel ≥ NUM_CH) or op 11: no state change, rsp_data=0, rsp_err=1.
- Response fields are stable from rsp_valid rising until the handshake completes.

## Timing
- Reset values:
  - State IDLE; cmd_ready=1 in the first cycle after reset deasserts, 0 while reset is high.
  - led_commands=0, rsp_valid=0, rsp_data=0, rsp_err=0, touched=0, threshold=all ones.
- Latency and throughput:
  - Command accepted at edge T → EXEC → rsp_valid high after edge T+1.
  - If rsp_ready is already high, a new command can be accepted at edge T+3 at the earliest; peak throughput is one command per 3 cycles.
  - led_commands changes on edge T+1.
- Reset priority: reset at any point, including in EXEC or RESP, wins. A pending command is dropped, the LED write does not occur, and the response is discarded.
- cmd_valid in EXEC or RESP is ignored; the command is not accepted because cmd_ready=0.
- rsp_ready outside RESP has no effect.

## Configuration
- Macro CAP_THRESHOLD_EN.
- Defined:
  - One DATA_W threshold register, written by op 10 (cmd_sel ignored). rsp_err=0.
  - touched[i] is registered every cycle as (sensor slice i > threshold). It therefore lags the sensor input by 1 cycle.
- Undefined:
  - Op 10 is treated as reserved: rsp_err=1, no state change.
  - touched is tied to 0 and no threshold register exists.

## Structure
- Shared package io_periph_pkg holds:
  - op encodings OP_LED, OP_CAP, OP_THR, OP_RSV
  - FSM state encoding IDLE/EXEC/RESP
- Sub-module cap_threshold, instantiated only under CAP_THRESHOLD_EN. It contains the threshold register and the NUM_CH comparators with their registers.
- Channel slicing is done with indexed part-selects; there is no per-channel case statement.

## Test plan
- LED write: op=00, sel=3, data=0x0000ABCD, rsp_ready=1 → led_commands[63:48]=0xABCD after edge T+1, all other slices 0, rsp_valid at T+1 with rsp_err=0.
- CAP snapshot under backpressure: sensor ch 8 =0x12345678, op=01, sel=8, rsp_ready held low 5 cycles while ch 8 changes to 0 → rsp_data stays 0x12345678 and rsp_valid stays high until rsp_ready.
- Invalid channel: sel=9 with NUM_CH=9, op=00 data=0xFFFF → rsp_err=1, rsp_data=0, led_commands unchanged.
- Reset mid-command: accept an LED write to sel=0, assert reset on the EXEC edge → led_commands stays 0, rsp_valid never rises, cmd_ready returns after reset.
- Threshold (macro on): op=10 data=100, sensor ch 2 =101, ch 5 =100 → touched=9'b000000100 one cycle later. Macro off: same op → rsp_err=1 and touched=0.
- Back-to-back commands: cmd_valid held with 3 queued commands and rsp_ready=1 → accepts exactly every 3 cycles, responses returned in order.
